// File: rtl/ps2_pkg.sv
// Shared PS/2 types, command constants and parity helper.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    INHIBIT = 3'd1,
    REQ     = 3'd2,
    SHIFT   = 3'd3,
    ACK     = 3'd4,
    FINISH  = 3'd5
  } tx_state_t;

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] RESP_ACK     = 8'hFA;

  localparam int unsigned BIT_CNT_W = 4;
  localparam logic [BIT_CNT_W-1:0] BIT_CNT_MAX = 4'd11;

  // PS/2 frames carry odd parity: the parity bit makes the total count of ones odd.
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for one PS/2 line plus a registered falling-edge strobe.
module ps2_line_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic fall
);

  logic meta;
  logic level_d;

  // Lines idle high, so reset to 1 to avoid a false edge after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta    <= 1'b1;
      level   <= 1'b1;
      level_d <= 1'b1;
      fall    <= 1'b0;
    end else begin
      meta    <= raw;
      level   <= meta;
      level_d <= level;
      fall    <= level_d & ~level;
    end
  end

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter with ACK check and line timeout.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 750000
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_error
);

  localparam int unsigned CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES
                                                                      : TIMEOUT_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  tx_state_t            state, state_next;
  logic [CNT_W-1:0]     cnt, cnt_next;
  logic [BIT_CNT_W-1:0] bit_cnt, bit_cnt_next;
  logic [BIT_CNT_W-1:0] bit_inc;
  logic [7:0]           byte_q, byte_next;
  logic                 par_q, par_next;
  logic                 ack_err, ack_err_next;
  logic                 clk_oe_next, dat_oe_next;
  logic                 done_next, err_next;

  logic clk_lvl, clk_fall;
  logic dat_lvl, dat_fall_unused;
  logic inhibit_last, inhibit_pre_last, timeout;

  ps2_line_sync u_clk_sync (
    .clk   (CLOCK_50),
    .rst_n (resetn),
    .raw   (ps2_clk_in),
    .level (clk_lvl),
    .fall  (clk_fall)
  );

  ps2_line_sync u_dat_sync (
    .clk   (CLOCK_50),
    .rst_n (resetn),
    .raw   (ps2_dat_in),
    .level (dat_lvl),
    .fall  (dat_fall_unused)
  );

  // Counter decodes and saturating bit-count increment.
  always_comb begin
    inhibit_last     = (cnt == CNT_W'(INHIBIT_CYCLES - 1));
    inhibit_pre_last = (cnt == CNT_W'(INHIBIT_CYCLES - 2));
    timeout          = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    bit_inc          = (bit_cnt >= BIT_CNT_MAX) ? BIT_CNT_MAX : bit_cnt + 4'd1;
  end

  // Next-state and next-output logic; outputs are registered from these values.
  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    bit_cnt_next = bit_cnt;
    byte_next    = byte_q;
    par_next     = par_q;
    ack_err_next = ack_err;
    clk_oe_next  = 1'b0;
    dat_oe_next  = ps2_dat_oe;
    done_next    = 1'b0;
    err_next     = 1'b0;

    unique case (state)
      IDLE: begin
        dat_oe_next = 1'b0;
        if (tx_valid) begin
          state_next   = INHIBIT;
          cnt_next     = '0;
          bit_cnt_next = '0;
          byte_next    = tx_data;
          par_next     = odd_parity(tx_data);
          ack_err_next = 1'b0;
          clk_oe_next  = 1'b1;
          dat_oe_next  = (INHIBIT_CYCLES == 1);
        end
      end

      INHIBIT: begin
        clk_oe_next = 1'b1;
        cnt_next    = cnt + CNT_W'(1);
        if (inhibit_pre_last) dat_oe_next = 1'b1;
        if (inhibit_last) begin
          state_next  = REQ;
          cnt_next    = '0;
          clk_oe_next = 1'b0;
          dat_oe_next = 1'b1;
        end
      end

      // Start bit held low; the first device clock fall presents data bit 0.
      REQ: begin
        cnt_next = cnt + CNT_W'(1);
        if (clk_fall) begin
          state_next   = SHIFT;
          cnt_next     = '0;
          bit_cnt_next = bit_inc;
          dat_oe_next  = ~byte_q[0];
        end else if (timeout) begin
          state_next  = FINISH;
          dat_oe_next = 1'b0;
          err_next    = 1'b1;
        end
      end

      SHIFT: begin
        cnt_next = cnt + CNT_W'(1);
        if (clk_fall) begin
          cnt_next     = '0;
          bit_cnt_next = bit_inc;
          if (bit_inc <= 4'd8) begin
            dat_oe_next = ~byte_q[bit_cnt[2:0]];
          end else if (bit_inc == 4'd9) begin
            dat_oe_next = ~par_q;
          end else begin
            dat_oe_next = 1'b0;
            state_next  = ACK;
          end
        end else if (timeout) begin
          state_next  = FINISH;
          dat_oe_next = 1'b0;
          err_next    = 1'b1;
        end
      end

      // Sample the device ACK on fall 11, then wait for the clock to return high.
      ACK: begin
        dat_oe_next = 1'b0;
        cnt_next    = cnt + CNT_W'(1);
        if (bit_cnt != BIT_CNT_MAX) begin
          if (clk_fall) begin
            cnt_next     = '0;
            bit_cnt_next = bit_inc;
            ack_err_next = dat_lvl;
          end else if (timeout) begin
            state_next = FINISH;
            err_next   = 1'b1;
          end
        end else if (clk_lvl) begin
          state_next = FINISH;
          done_next  = ~ack_err;
          err_next   = ack_err;
        end else if (timeout) begin
          state_next = FINISH;
          err_next   = 1'b1;
        end
      end

      FINISH: begin
        dat_oe_next = 1'b0;
        state_next  = IDLE;
      end

      default: begin
        dat_oe_next = 1'b0;
        state_next  = IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_cnt    <= '0;
      byte_q     <= '0;
      par_q      <= 1'b0;
      ack_err    <= 1'b0;
      ps2_clk_oe <= 1'b0;
      ps2_dat_oe <= 1'b0;
      busy       <= 1'b0;
      tx_ready   <= 1'b1;
      tx_done    <= 1'b0;
      tx_error   <= 1'b0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      bit_cnt    <= bit_cnt_next;
      byte_q     <= byte_next;
      par_q      <= par_next;
      ack_err    <= ack_err_next;
      ps2_clk_oe <= clk_oe_next;
      ps2_dat_oe <= dat_oe_next;
      busy       <= (state_next != IDLE);
      tx_ready   <= (state_next == IDLE);
      tx_done    <= done_next;
      tx_error   <= err_next;
    end
  end

endmodule
